// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one RV32I memory port between instruction fetch and the LSU,
// round-robin on conflict, one outstanding transaction, registered responses.
module rv32_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DATA_W/8-1:0] lsu_req_be,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic                last_lsu_q, last_lsu_d;
    logic                owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                if_rsp_valid_q, if_rsp_valid_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic                idle;
    logic                grant_lsu;

    // On conflict the LSU wins unless it won the previous acceptance.
    assign idle          = rst_n && (state_q == IDLE);
    assign grant_lsu     = lsu_req_valid && (!if_req_valid || !last_lsu_q);
    assign if_req_ready  = idle && if_req_valid && !grant_lsu;
    assign lsu_req_ready = idle && grant_lsu;

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_rdata  = if_rdata_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_rdata = lsu_rdata_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d         = state_q;
        last_lsu_d      = last_lsu_q;
        owner_lsu_d     = owner_lsu_q;
        addr_d          = addr_q;
        we_d            = we_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        if_rdata_d      = if_rdata_q;
        lsu_rdata_d     = lsu_rdata_q;
        if_rsp_valid_d  = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req_ready || lsu_req_ready) begin
                    state_d     = REQ;
                    last_lsu_d  = lsu_req_ready;
                    owner_lsu_d = lsu_req_ready;
                    addr_d      = lsu_req_ready ? lsu_req_addr : if_req_addr;
                    we_d        = lsu_req_ready && lsu_req_we;
                    be_d        = lsu_req_ready ? lsu_req_be : '1;
                    wdata_d     = lsu_req_ready ? lsu_req_wdata : '0;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_lsu_q) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_rdata_d     = mem_rsp_rdata;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rdata_d     = mem_rsp_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_lsu_q      <= 1'b0;
            owner_lsu_q     <= 1'b0;
            addr_q          <= '0;
            we_q            <= 1'b0;
            be_q            <= '0;
            wdata_q         <= '0;
            if_rdata_q      <= '0;
            lsu_rdata_q     <= '0;
            if_rsp_valid_q  <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_lsu_q      <= last_lsu_d;
            owner_lsu_q     <= owner_lsu_d;
            addr_q          <= addr_d;
            we_q            <= we_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            if_rdata_q      <= if_rdata_d;
            lsu_rdata_q     <= lsu_rdata_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
        end
    end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: randomized + directed bench with a memory model, a reference
// arbitration/memory model and a scoreboard monitor checking every DUT output.
module tb_rv32_mem_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
    logic [31:0] if_req_addr = '0, if_rsp_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_req_we = 1'b0, lsu_rsp_valid;
    logic [3:0]  lsu_req_be = '0;
    logic [31:0] lsu_req_addr = '0, lsu_req_wdata = '0, lsu_rsp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, busy;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;

    always #5 clk = ~clk;

    rv32_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_we(lsu_req_we), .lsu_req_be(lsu_req_be), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
    );

    typedef struct {bit lsu; bit st; logic [31:0] data;} rsp_t;
    typedef struct {bit lsu; logic [31:0] addr; bit we; logic [3:0] be; logic [31:0] wdata;} req_t;

    rsp_t        exp_q[$];
    req_t        req_q[$];
    bit          grant_log[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slv_mem[int];
    int          checks = 0, failures = 0;
    bit          bp_force = 0, spur_en = 0, rand_delay = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8+:8] = nw[i*8+:8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] slv_rd(input int w);
        return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
    endfunction

    // Memory slave: random ready and response latency, or zero-wait in directed phases.
    initial begin
        bit hs = 0, fired = 0, outst = 0;
        int cnt = 0, w;
        logic [31:0] rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                outst = 0; hs = 0; fired = 0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
                continue;
            end
            if (fired) outst = 0;
            if (hs) begin
                outst = 1;
                w = int'(mem_addr[31:2]);
                if (mem_we) slv_mem[w] = merge(slv_rd(w), mem_wdata, mem_be);
                rd = slv_rd(w);
                cnt = rand_delay ? int'($urandom_range(0, 3)) : 0;
            end
            if (outst && cnt == 0) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = rd;
            end else begin
                if (outst) cnt--;
                mem_rsp_valid = !outst && spur_en; mem_rsp_rdata = $urandom;
            end
            mem_req_ready = bp_force ? 1'b0 : (rand_delay ? ($urandom_range(0, 3) != 0) : 1'b1);
            #1;
            hs = mem_req_valid && mem_req_ready;
            fired = mem_rsp_valid && outst;
        end
    end

    // Scoreboard monitor: arbitration model, request fields, response routing and timing.
    initial begin
        bit last_lsu = 0, waiting = 0, wait_lsu = 0, pend = 0, pend_lsu = 0, stall = 0, exp_lsu;
        req_t snap, r;
        rsp_t e;
        int w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); req_q.delete(); grant_log.delete();
                last_lsu = 0; waiting = 0; pend = 0; stall = 0;
                continue;
            end
            chk(if_rsp_valid == (pend && !pend_lsu), "if_rsp_timing", 32'(if_rsp_valid), 32'(pend && !pend_lsu));
            chk(lsu_rsp_valid == (pend && pend_lsu), "lsu_rsp_timing", 32'(lsu_rsp_valid), 32'(pend && pend_lsu));
            if (if_rsp_valid || lsu_rsp_valid) begin
                if (exp_q.size() == 0) chk(0, "unexpected_rsp", 32'({if_rsp_valid, lsu_rsp_valid}), 0);
                else begin
                    e = exp_q.pop_front();
                    chk(lsu_rsp_valid == e.lsu, "rsp_owner", 32'(lsu_rsp_valid), 32'(e.lsu));
                    if (!e.st) chk((e.lsu ? lsu_rsp_rdata : if_rsp_rdata) == e.data, "rsp_rdata",
                                   e.lsu ? lsu_rsp_rdata : if_rsp_rdata, e.data);
                end
            end
            pend = 0;
            if (waiting && mem_rsp_valid) begin
                pend = 1; pend_lsu = wait_lsu; waiting = 0;
            end
            if (stall) chk(mem_req_valid && mem_addr == snap.addr && mem_we == snap.we &&
                           mem_be == snap.be && mem_wdata == snap.wdata, "req_stable", mem_addr, snap.addr);
            stall = mem_req_valid && !mem_req_ready;
            snap = '{lsu: 0, addr: mem_addr, we: mem_we, be: mem_be, wdata: mem_wdata};
            chk(!(if_req_ready && lsu_req_ready), "ready_excl", 32'({if_req_ready, lsu_req_ready}), 0);
            if (busy) chk(!if_req_ready && !lsu_req_ready, "ready_busy", 32'({if_req_ready, lsu_req_ready}), 0);
            else if (if_req_valid || lsu_req_valid) begin
                exp_lsu = lsu_req_valid && (!if_req_valid || !last_lsu);
                chk(if_req_ready == !exp_lsu && lsu_req_ready == exp_lsu, "grant",
                    32'({if_req_ready, lsu_req_ready}), 32'({!exp_lsu, exp_lsu}));
                grant_log.push_back(lsu_req_ready);
                last_lsu = exp_lsu;
                if (exp_lsu) begin
                    w = int'(lsu_req_addr[31:2]);
                    if (lsu_req_we) ref_mem[w] = merge(ref_rd(w), lsu_req_wdata, lsu_req_be);
                    req_q.push_back('{lsu: 1, addr: lsu_req_addr, we: lsu_req_we, be: lsu_req_be, wdata: lsu_req_wdata});
                    exp_q.push_back('{lsu: 1, st: lsu_req_we, data: ref_rd(w)});
                end else begin
                    req_q.push_back('{lsu: 0, addr: if_req_addr, we: 0, be: 4'hF, wdata: '0});
                    exp_q.push_back('{lsu: 0, st: 0, data: ref_rd(int'(if_req_addr[31:2]))});
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) chk(0, "unexpected_mem_req", mem_addr, 0);
                else begin
                    r = req_q.pop_front();
                    chk(mem_addr == r.addr, "mem_addr", mem_addr, r.addr);
                    chk({mem_we, mem_be} == {r.we, r.be}, "mem_we_be", 32'({mem_we, mem_be}), 32'({r.we, r.be}));
                    if (r.we) chk(mem_wdata == r.wdata, "mem_wdata", mem_wdata, r.wdata);
                    waiting = 1; wait_lsu = r.lsu;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid, mem_req_valid, busy} == 0,
            {tag, "_ctrl"}, 32'({if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid, mem_req_valid, busy}), 0);
        chk(mem_addr == 0, {tag, "_addr"}, mem_addr, 0);
        chk(mem_wdata == 0, {tag, "_wdata"}, mem_wdata, 0);
        chk({mem_we, mem_be} == 0, {tag, "_we_be"}, 32'({mem_we, mem_be}), 0);
        chk(if_rsp_rdata == 0, {tag, "_if_rdata"}, if_rsp_rdata, 0);
        chk(lsu_rsp_rdata == 0, {tag, "_lsu_rdata"}, lsu_rsp_rdata, 0);
    endtask

    task automatic req_if(input logic [31:0] a);
        bit acc = 0;
        int n = 0;
        if_req_valid = 1'b1; if_req_addr = a;
        while (!acc && n < 50) begin
            #1; acc = if_req_ready; cyc(); n++;
        end
        if (!acc) chk(0, "if_accept_timeout", 32'(n), 50);
        if_req_valid = 1'b0;
    endtask

    task automatic req_lsu(input logic [31:0] a, input bit we, input logic [3:0] be, input logic [31:0] d);
        bit acc = 0;
        int n = 0;
        lsu_req_valid = 1'b1; lsu_req_addr = a; lsu_req_we = we; lsu_req_be = be; lsu_req_wdata = d;
        while (!acc && n < 50) begin
            #1; acc = lsu_req_ready; cyc(); n++;
        end
        if (!acc) chk(0, "lsu_accept_timeout", 32'(n), 50);
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            cyc(); n++;
        end
        if (n >= 300) chk(0, "idle_timeout", 32'(n), 300);
    endtask

    initial begin
        bit if_acc = 0, lsu_acc = 0, if_seen = 0, got = 0;
        int n;
        repeat (2) cyc();
        #2 check_reset("init_reset");
        rst_n = 1'b1;
        cyc();

        // single fetch, zero-wait memory
        ref_mem[32'h40] = 32'h0050_0093; slv_mem[32'h40] = 32'h0050_0093;
        req_if(32'h0000_0100);
        @(negedge clk);
        chk(mem_req_valid && mem_addr == 32'h100, "fetch_req", mem_addr, 32'h100);
        chk({mem_we, mem_be} == 5'h0F, "fetch_we_be", 32'({mem_we, mem_be}), 32'h0F);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = if_rsp_valid;
        end
        chk(got && if_rsp_rdata == 32'h0050_0093, "fetch_rdata", if_rsp_rdata, 32'h0050_0093);
        @(negedge clk);
        chk(!if_rsp_valid, "fetch_pulse_width", 32'(if_rsp_valid), 0);
        cyc();

        // store, then read it back
        req_lsu(32'h0000_2004, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        @(negedge clk);
        chk(mem_addr == 32'h2004 && mem_wdata == 32'hDEAD_BEEF, "store_fields", mem_wdata, 32'hDEAD_BEEF);
        chk({mem_we, mem_be} == 5'h13, "store_we_be", 32'({mem_we, mem_be}), 32'h13);
        got = 0; if_seen = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); got = lsu_rsp_valid; if_seen |= if_rsp_valid;
        end
        chk(got, "store_done", 32'(got), 1);
        chk(!if_seen, "store_no_if_rsp", 32'(if_seen), 0);
        cyc(); wait_idle();
        req_lsu(32'h0000_2004, 1'b0, 4'hF, 32'h0);
        wait_idle();

        // back-pressure
        bp_force = 1; cyc();
        req_lsu(32'h0000_3008, 1'b0, 4'hF, 32'h0);
        if_req_valid = 1'b1; if_req_addr = 32'h8; lsu_req_valid = 1'b1; lsu_req_addr = 32'hC;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(mem_req_valid && mem_addr == 32'h3008 && !mem_we && mem_be == 4'hF, "bp_hold", mem_addr, 32'h3008);
            chk(!if_req_ready && !lsu_req_ready, "bp_no_ready", 32'({if_req_ready, lsu_req_ready}), 0);
        end
        cyc();
        if_req_valid = 1'b0; lsu_req_valid = 1'b0; bp_force = 0;
        wait_idle();

        // spurious memory response while idle
        spur_en = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) spur_en = 0;
            @(negedge clk);
            chk(!busy && !if_rsp_valid && !lsu_rsp_valid, "spurious", 32'({busy, if_rsp_valid, lsu_rsp_valid}), 0);
        end
        cyc();

        // reset while stuck in REQ, then contention
        bp_force = 1; cyc();
        req_if(32'h0000_0040);
        @(negedge clk);
        chk(busy && mem_req_valid, "pre_reset_req", 32'({busy, mem_req_valid}), 3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h14;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h18; lsu_req_we = 1'b0; lsu_req_be = 4'hF;
        #1 check_reset("mid_reset");
        bp_force = 0;
        repeat (2) @(posedge clk);
        #3 check_reset("mid_reset_hold");
        rst_n = 1'b1;
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin
            cyc(); n++;
        end
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        chk(grant_log.size() == 6, "contention_count", 32'(grant_log.size()), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk(grant_log[i] == (i % 2 == 0), "grant_order", 32'(grant_log[i]), 32'(i % 2 == 0));
        wait_idle();

        // randomized traffic
        rand_delay = 1;
        for (int c = 0; c < 600; c++) begin
            if (!if_req_valid || if_acc) begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_req_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!lsu_req_valid || lsu_acc) begin
                lsu_req_valid = 1'($urandom_range(0, 1));
                lsu_req_addr = 32'($urandom_range(0, 15)) << 2;
                lsu_req_we = 1'($urandom_range(0, 1));
                lsu_req_be = 4'($urandom_range(1, 15));
                lsu_req_wdata = $urandom;
            end
            #1;
            if_acc = if_req_valid && if_req_ready;
            lsu_acc = lsu_req_valid && lsu_req_ready;
            cyc();
        end
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        wait_idle();
        repeat (2) cyc();
        chk(exp_q.size() == 0, "rsp_queue_empty", 32'(exp_q.size()), 0);
        chk(req_q.size() == 0, "req_queue_empty", 32'(req_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Arbitrates the single RV32I memory port between the instruction-fetch unit (IF) and the load/store unit (LSU). It accepts one request at a time from either requester, drives it onto the memory port with a valid/ready handshake, waits for the memory response, and routes the registered response back to the requester that issued it. When both requesters are pending, a round-robin decision picks the winner, so neither requester can starve the other.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request pending
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  one-cycle pulse; fetch data valid
- if_rsp_rdata  out  DATA_W  fetched instruction word
- lsu_req_valid  in  1  load/store request pending
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_we  in  1  1 = store, 0 = load
- lsu_req_be  in  DATA_W/8  store byte enables
- lsu_req_wdata  in  DATA_W  store data
- lsu_rsp_valid  out  1  one-cycle pulse; load data valid or store completed
- lsu_rsp_rdata  out  DATA_W  load data; don't-care for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_we, mem_be, mem_wdata  out  ADDR_W/1/DATA_W/8/DATA_W  request fields
- mem_rsp_valid  in  1  memory response
- mem_rsp_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: ready for the winning requester = its valid AND the grant. At most one of if_req_ready and lsu_req_ready is high in a cycle. On acceptance, register addr/we/be/wdata and owner, then go to REQ.
  - Only IF valid: IF wins.
  - Only LSU valid: LSU wins.
  - Both valid: the requester that did not win last time wins.
  - `last_grant` updates only on acceptance.
- IF requests drive mem_we=0 and mem_be=all ones.
- REQ: mem_req_valid=1, driven from registers, with fields stable until the handshake. On mem_req_valid && mem_req_ready, go to WAIT.
- WAIT: on mem_rsp_valid, register mem_rsp_rdata into the owner's rdata and pulse the owner's rsp_valid on the next cycle. Go to IDLE on the same edge.
- Ignored mem_rsp_valid: in IDLE or REQ it is a protocol violation; the block ignores it and asserts nothing.
- Store completion: stores also wait for mem_rsp_valid, and lsu_rsp_valid pulses to signal completion.
- Non-owner rdata: holds its previous value.
- Reset (any time, including mid-transaction):
  - state=IDLE and last_grant=IF, so LSU wins the first conflict.
  - All ready, valid and busy outputs = 0; rdata and registered fields = 0.
  - Any in-flight transaction is dropped with no response.

## Timing
- Request accepted at edge N (ready high in cycle N-1) → mem_req_valid high from cycle N.
- Handshake at edge M → WAIT from cycle M.
- mem_rsp_valid sampled at edge K → rsp_valid high in cycle K only, for exactly one cycle.
- Minimum turnaround with a zero-wait memory (ready in the first REQ cycle, response in the first WAIT cycle):
  - accept, REQ and WAIT each take one cycle, then the rsp pulse follows.
  - The next request can be accepted in the cycle the rsp pulse is high, because the FSM is in IDLE then.
  - Throughput: one transaction per 3 cycles.
- mem_req_ready low: the FSM holds REQ indefinitely, with request fields unchanged.
- Requester valid dropping after acceptance: no effect on the transaction.
- No combinational path from mem_rsp_* to if_/lsu_rsp_*.
- ready is combinational from the requester valids and the FSM state.

## Test plan
- **Reset values:** hold rst_n=0 mid-REQ with mem_req_ready=0, then release.
  - Required: all outputs 0, busy=0, and no response pulse.
  - The next request proceeds normally.
- **Single fetch:** if_req_addr=0x0000_0100, memory returns 0x0050_0093 one cycle after the handshake.
  - Required: if_rsp_valid high for one cycle with if_rsp_rdata=0x0050_0093.
  - Required: mem_we=0, mem_be=4'hF.
- **Store:** lsu addr 0x0000_2004, we=1, be=4'b0011, wdata=0xDEAD_BEEF.
  - Required: mem fields match the request exactly.
  - Required: lsu_rsp_valid pulses once after mem_rsp_valid.
  - Required: if_rsp_valid stays 0.
- **Contention:** both valid continuously for 6 transactions after reset.
  - Required grant order: LSU, IF, LSU, IF, LSU, IF.
  - Required: each response is routed to the correct owner.
- **Back-pressure:** mem_req_ready low for 5 cycles.
  - Required: mem_addr, mem_we, mem_be and mem_wdata are stable and mem_req_valid stays high for all 5 cycles.
  - Required: neither requester ready is high during those cycles.
- **Spurious response:** mem_rsp_valid asserted while IDLE.
  - Required: no if_rsp_valid or lsu_rsp_valid pulse, and no state change.
